// File: rtl/display_scan4.sv
// Four-digit multiplexed display scanner: one nibble at a time, one-hot enables,
// dead time between slots, optional leading-zero blanking, frame-aligned updates.
module display_scan4 #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic        Blank_lz,
  output logic [3:0]  Digit,
  output logic [3:0]  Digit_en,
  output logic        Pending,
  output logic        Ack
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {DEAD = 1'b0, ON = 1'b1} state_t;
  localparam state_t RST_STATE = (DEAD_CYCLES == 0) ? ON : DEAD;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q;
  logic [15:0]   staging_q, disp_q;
  logic          pending_q, ack_q, blz_q;
  logic          slot_end, frame_end, dead_d;
  logic          lz3, lz2, lz1;
  logic [3:0]    blank_mask;

  assign slot_end  = (cnt_q == LAST);
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
  assign idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign dead_d = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYCLES);
      assign dead_d = (cnt_d < DEAD_C);
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      state_q   <= RST_STATE;
      staging_q <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      blz_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= dead_d ? DEAD : ON;
      blz_q   <= Blank_lz;
      ack_q   <= frame_end && pending_q;
      // Transfer uses the pre-edge staging, so a colliding Load stays pending
      if (frame_end && pending_q) disp_q <= staging_q;
      if (Load) begin
        staging_q <= Value;
        pending_q <= 1'b1;
      end else if (frame_end) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign lz3 = (disp_q[15:12] == 4'd0);
  assign lz2 = lz3 && (disp_q[11:8] == 4'd0);
  assign lz1 = lz2 && (disp_q[7:4] == 4'd0);
  assign blank_mask = blz_q ? {lz3, lz2, lz1, 1'b0} : 4'b0000;

  assign Digit   = disp_q[{idx_q, 2'b00} +: 4];
  assign Pending = pending_q;
  assign Ack     = ack_q;

  // Without dead time the reset state is ON, so reset itself must hold enables low
  assign Digit_en = (state_q == ON && !Rst) ? ((4'b0001 << idx_q) & ~blank_mask) : 4'b0000;

endmodule

// File: doc/display_scan4.md
# display_scan4

Four-digit time-multiplexed display scanner for the calculator datapath. Holds a 16-bit value of four 4-bit digits and presents one digit at a time on a 4-bit bus that feeds the binary-to-8-segment decoder. It drives a one-hot digit enable, inserts dead time between digits to prevent ghosting, and optionally blanks leading zeros. New values are accepted via a load/ack handshake and take effect only at frame boundaries, so a frame never shows a partial update.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- DEAD_CYCLES, 1: cycles at the start of each slot with all enables low; legal range 0 ≤ DEAD_CYCLES < REFRESH_DIV.
- Clk  in  1  system clock; all state is updated on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Value  in  16  digits to display; Value[3:0] is digit 0 (least significant), Value[15:12] is digit 3.
- Load  in  1  request to capture Value; sampled each Clk edge.
- Blank_lz  in  1  leading-zero blanking enable.
- Digit  out  4  nibble of the current digit; drives the decoder input.
- Digit_en  out  4  one-hot digit enable, active-high; bit i selects digit i.
- Pending  out  1  a captured value is waiting for the next frame boundary.
- Ack  out  1  one-cycle pulse: the pending value has become the displayed value.

## Operation
- Registers:
  - staging[15:0] holds the most recently loaded value.
  - disp[15:0] holds the displayed value.
  - Pending.
  - A prescaler counter counts 0..REFRESH_DIV-1.
  - A 2-bit digit index idx counts 0..3 and wraps.
  - State is DEAD or ON.
  - blz_q is the registered copy of Blank_lz.
- Slot sequence:
  - At prescaler 0 the state is DEAD; it stays DEAD while prescaler < DEAD_CYCLES, then becomes ON until prescaler = REFRESH_DIV-1.
  - When prescaler = REFRESH_DIV-1, the prescaler wraps to 0 and idx increments (3 wraps to 0).
  - If DEAD_CYCLES = 0, DEAD is never entered.
- Frame boundary: the cycle with idx = 3 and prescaler = REFRESH_DIV-1.
  - If Pending = 1 on that cycle: disp ← staging, Pending ← 0, and Ack = 1 on the next cycle only.
- Load handling:
  - When Load = 1: staging ← Value and Pending ← 1.
  - Load while Pending = 1 overwrites staging; the latest value wins and no extra Ack is generated.
  - Load on the frame-boundary cycle: the transfer uses the staging contents from before that edge, and Pending stays 1 because the new value transfers at the next boundary. Ack still pulses.
- Outputs:
  - Digit = disp[4*idx+3 : 4*idx] in both states.
  - Digit_en = 0 in DEAD. In ON, Digit_en = one-hot(idx) unless the digit is blanked.
- Blanking: when blz_q = 1, digit i (i ≥ 1) is blanked if disp[15 : 4*i] == 0. Digit 0 is never blanked, so value 0 shows a single "0".
- All outputs are functions of registers only, with no combinational path from any input.
- Reset (asynchronous, immediate):
  - staging, disp, prescaler, idx = 0.
  - Pending, Ack, blz_q = 0.
  - State = DEAD, or ON if DEAD_CYCLES = 0.
  - Digit = 0 and Digit_en = 0 while Rst is high.
- Reset mid-frame or mid-handshake discards staging and disp; no Ack is issued afterwards for a pre-reset Load.

## Timing
- Frame length = 4 × REFRESH_DIV cycles. Each digit's ON time = REFRESH_DIV − DEAD_CYCLES cycles.
- After Rst deasserts, the first Clk edge is prescaler count 0 of slot idx = 0.
- Digit changes at the first cycle of a slot, i.e. during dead time, never while its enable is high.
- Load latency:
  - Pending is high the cycle after the Load edge.
  - disp updates at the next frame boundary edge, between 1 and 4 × REFRESH_DIV cycles after Load.
  - Ack is high the cycle after that edge.
- Blank_lz takes effect on Digit_en one cycle after it is sampled.

## Test plan
- Reset: with REFRESH_DIV=8 and DEAD_CYCLES=2, hold Rst mid-scan → immediately Digit=0, Digit_en=0, Pending=0, Ack=0; after release, Digit_en=0001 at cycles 2–7, 0010 at cycles 10–15, 0100 at cycles 18–23, 1000 at cycles 26–31, then back to 0001.
- Load/ack: pulse Load with Value=16'h1234 at cycle 5 → Pending=1 from cycle 6; disp updates at the boundary (cycle 31 edge) with Ack=1 for one cycle; the next frame shows Digit=4,3,2,1 for idx 0..3.
- Overwrite: Load 16'hAAAA, then Load 16'h5555 before the boundary → exactly one Ack, and 16'h5555 is displayed.
- Boundary collision: Load 16'h0007 exactly on the boundary cycle while staging=16'h1111 is pending → 16'h1111 is displayed with Ack; Pending stays 1; 16'h0007 is shown after the following boundary with a second Ack.
- Blanking: disp=16'h0070 with Blank_lz=1 → Digit_en pulses only 0001 and 0010 per frame. disp=16'h0000 → only 0001. With Blank_lz=0 → all four enables pulse.
- DEAD_CYCLES=0, REFRESH_DIV=2: enables rotate 0001, 0010, 0100, 1000 with two cycles each and no gaps; Digit always matches the enabled nibble.
